// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, FSM state type and width helpers for the FFT address sequencer.
package fft_pkg;

    localparam int LOG2N_DEF = 4;
    localparam int CPLX_W    = 16;
    localparam int FP8_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

    function automatic int addr_w(input int log2n);
        return log2n;
    endfunction

    function automatic int tw_w(input int log2n);
        return log2n - 1;
    endfunction

    function automatic int stage_w(input int log2n);
        return (log2n <= 2) ? 1 : $clog2(log2n);
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - async-reset shift register carrying {valid,addr_a,addr_b} to write-back.
module fft_delay_line #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/fft_bfly_addr_gen.sv
// rtl/fft_bfly_addr_gen.sv - radix-2 DIT butterfly read/twiddle/write-back address sequencer.
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N    = LOG2N_DEF,
    parameter int PIPE_LAT = 2,
    localparam int AW = addr_w(LOG2N),
    localparam int TW = tw_w(LOG2N),
    localparam int SW = stage_w(LOG2N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr_a,
    output logic [AW-1:0] o_rd_addr_b,
    output logic [TW-1:0] o_tw_addr,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr_a,
    output logic [AW-1:0] o_wr_addr_b,
    output logic [SW-1:0] o_stage
);

    localparam int KW = LOG2N - 1;
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam int DW = 1 + 2 * AW;
    localparam logic [KW-1:0] K_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
    localparam logic [FW-1:0] F_LAST = FW'(PIPE_LAT - 1);

    fsm_state_t    r_state, w_next;
    logic [KW-1:0] r_k;
    logic [SW-1:0] r_s;
    logic [FW-1:0] r_fcnt;
    logic [AW-1:0] r_hold_a, r_hold_b;
    logic [TW-1:0] r_hold_tw;

    logic [AW-1:0] w_span, w_k_ext, w_pos, w_grp, w_a, w_b;
    logic [TW-1:0] w_tw;
    logic [DW-1:0] w_dl_q;

    // pos selects the element within a group, grp selects the group of 2*span entries
    assign w_span  = AW'(1) << r_s;
    assign w_k_ext = AW'(r_k);
    assign w_pos   = w_k_ext & (w_span - AW'(1));
    assign w_grp   = w_k_ext >> r_s;
    assign w_a     = ((w_grp << r_s) << 1) | w_pos;
    assign w_b     = w_a + w_span;
    assign w_tw    = TW'(w_pos) << (S_LAST - r_s);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = RUN;
            RUN:     if (r_k == K_LAST) w_next = FLUSH;
            FLUSH:   if (r_fcnt == F_LAST) w_next = (r_s == S_LAST) ? DONE : RUN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_k       <= '0;
            r_s       <= '0;
            r_fcnt    <= '0;
            r_hold_a  <= '0;
            r_hold_b  <= '0;
            r_hold_tw <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_k <= '0;
                        r_s <= '0;
                    end
                end
                RUN: begin
                    r_hold_a  <= w_a;
                    r_hold_b  <= w_b;
                    r_hold_tw <= w_tw;
                    r_fcnt    <= '0;
                    r_k       <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
                end
                FLUSH: begin
                    if (r_fcnt == F_LAST) begin
                        r_fcnt <= '0;
                        if (r_s != S_LAST) r_s <= r_s + 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rd_en     = (r_state == RUN);
    assign o_busy      = (r_state == RUN) || (r_state == FLUSH);
    assign o_done      = (r_state == DONE);
    assign o_rd_addr_a = o_rd_en ? w_a  : r_hold_a;
    assign o_rd_addr_b = o_rd_en ? w_b  : r_hold_b;
    assign o_tw_addr   = o_rd_en ? w_tw : r_hold_tw;
    assign o_stage     = r_s;

    fft_delay_line #(
        .W     (DW),
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     ({o_rd_en, o_rd_addr_a, o_rd_addr_b}),
        .o_q     (w_dl_q)
    );

    assign o_wr_en     = w_dl_q[DW-1];
    assign o_wr_addr_a = w_dl_q[2*AW-1:AW];
    assign o_wr_addr_b = w_dl_q[AW-1:0];

endmodule
